// File: rtl/mdr_pkg.sv
// Shared types and constants for the memory data register controller.
package mdr_pkg;

    typedef enum logic [1:0] {
        MDR_IDLE = 2'd0,
        MDR_RD   = 2'd1,
        MDR_WR   = 2'd2
    } mdr_state_e;

    localparam logic SZ_WORD = 1'b0;
    localparam logic SZ_BYTE = 1'b1;

    localparam int MDR_DATA_W  = 16;
    localparam int MDR_TIMEOUT = 8;

    // Even parity bit for one byte lane: makes the total count of ones even.
    function automatic logic byte_par(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/mdr_byte_ext.sv
// Byte lane select with zero/sign extension to the full data width.
module mdr_byte_ext
    import mdr_pkg::*;
#(
    parameter int DATA_W = MDR_DATA_W,
    parameter int NB     = DATA_W / 8
) (
    input  logic [DATA_W-1:0]     data_in,
    input  logic [$clog2(NB)-1:0] byte_sel,
    input  logic                  sign_ext,
    output logic [DATA_W-1:0]     data_out
);

    logic [7:0] lane_s;

    // Pick the addressed lane and fill the upper bits with zero or its sign.
    always_comb begin
        lane_s   = data_in[{byte_sel, 3'b000} +: 8];
        data_out = {{(DATA_W-8){sign_ext & lane_s[7]}}, lane_s};
    end

endmodule

// File: rtl/mdr_ctrl.sv
// Memory data register with req/ack memory handshake and bus timeout.
// Optional per-lane even parity on the memory port: define MDR_PARITY_EN.
module mdr_ctrl
    import mdr_pkg::*;
#(
    parameter int DATA_W  = MDR_DATA_W,
    parameter int NB      = DATA_W / 8,
    parameter int TIMEOUT = MDR_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_rd_req,
    input  logic                  cpu_wr_req,
    input  logic                  cpu_size,
    input  logic                  cpu_signed,
    input  logic [$clog2(NB)-1:0] cpu_byte_sel,
    input  logic [DATA_W-1:0]     cpu_wdata,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic                  cpu_done,
    output logic                  cpu_err,
    output logic                  busy,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [NB-1:0]         mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack
`ifdef MDR_PARITY_EN
    ,
    output logic [NB-1:0]         mem_wpar,
    input  logic [NB-1:0]         mem_rpar
`endif
);

    localparam int SEL_W = $clog2(NB);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] ST_IDLE = MDR_IDLE;
    localparam logic [1:0] ST_RD   = MDR_RD;
    localparam logic [1:0] ST_WR   = MDR_WR;

    logic [1:0]        state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              size_r;
    logic              signed_r;
    logic [SEL_W-1:0]  sel_r;
    logic [DATA_W-1:0] cpu_rdata_r;
    logic              cpu_done_r;
    logic              cpu_err_r;
    logic              busy_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [NB-1:0]     mem_be_r;
    logic [DATA_W-1:0] mem_wdata_r;

    logic [NB-1:0]     be_s;
    logic [DATA_W-1:0] wdata_s;
    logic [DATA_W-1:0] ext_s;
    logic [DATA_W-1:0] load_s;
    logic              expire_s;
    logic              par_err_s;

    assign cpu_rdata = cpu_rdata_r;
    assign cpu_done  = cpu_done_r;
    assign cpu_err   = cpu_err_r;
    assign busy      = busy_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_be    = mem_be_r;
    assign mem_wdata = mem_wdata_r;

    mdr_byte_ext #(
        .DATA_W (DATA_W),
        .NB     (NB)
    ) u_byte_ext (
        .data_in  (mem_rdata),
        .byte_sel (sel_r),
        .sign_ext (signed_r),
        .data_out (ext_s)
    );

    // Request encoding from the live CPU inputs, captured on entry to RD/WR.
    always_comb begin
        if (cpu_size == SZ_BYTE) begin
            be_s    = {{(NB-1){1'b0}}, 1'b1} << cpu_byte_sel;
            wdata_s = {NB{cpu_wdata[7:0]}};
        end else begin
            be_s    = {NB{1'b1}};
            wdata_s = cpu_wdata;
        end
    end

    // Load data selection and timeout expiry; ack in the expiry cycle wins.
    always_comb begin
        if (size_r == SZ_BYTE) begin
            load_s = ext_s;
        end else begin
            load_s = mem_rdata;
        end
        expire_s = (TIMEOUT != 0) && !mem_ack && (cnt_r == CNT_LAST);
    end

`ifdef MDR_PARITY_EN
    logic [NB-1:0] wpar_s;
    logic [NB-1:0] rpar_calc_s;
    logic [NB-1:0] mem_wpar_r;

    assign mem_wpar = mem_wpar_r;

    // Parity generation for outgoing data and checking on enabled read lanes.
    always_comb begin
        wpar_s      = {NB{1'b0}};
        rpar_calc_s = {NB{1'b0}};
        for (int i = 0; i < NB; i++) begin
            wpar_s[i]      = byte_par(wdata_s[8*i +: 8]);
            rpar_calc_s[i] = byte_par(mem_rdata[8*i +: 8]);
        end
        par_err_s = |((rpar_calc_s ^ mem_rpar) & mem_be_r);
    end

    // Parity register follows the write data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wpar_r <= {NB{1'b0}};
        end else if (state_r == ST_IDLE && (cpu_wr_req || cpu_rd_req)) begin
            mem_wpar_r <= wpar_s;
        end else begin
            mem_wpar_r <= mem_wpar_r;
        end
    end
`else
    assign par_err_s = 1'b0;
`endif

    // Transaction FSM and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            size_r      <= SZ_WORD;
            signed_r    <= 1'b0;
            sel_r       <= {SEL_W{1'b0}};
            cpu_rdata_r <= {DATA_W{1'b0}};
            cpu_done_r  <= 1'b0;
            cpu_err_r   <= 1'b0;
            busy_r      <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_be_r    <= {NB{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
        end else begin
            cpu_done_r <= 1'b0;
            cpu_err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= {CNT_W{1'b0}};
                    if (cpu_wr_req || cpu_rd_req) begin
                        state_r     <= cpu_wr_req ? ST_WR : ST_RD;
                        busy_r      <= 1'b1;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= cpu_wr_req;
                        mem_be_r    <= be_s;
                        mem_wdata_r <= wdata_s;
                        size_r      <= cpu_size;
                        signed_r    <= cpu_signed;
                        sel_r       <= cpu_byte_sel;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RD, ST_WR: begin
                    if (mem_ack || expire_s) begin
                        state_r    <= ST_IDLE;
                        cnt_r      <= {CNT_W{1'b0}};
                        busy_r     <= 1'b0;
                        mem_req_r  <= 1'b0;
                        cpu_done_r <= 1'b1;
                        if (!mem_ack) begin
                            cpu_err_r <= 1'b1;
                        end else if (state_r == ST_RD) begin
                            cpu_rdata_r <= load_s;
                            cpu_err_r   <= par_err_s;
                        end else begin
                            cpu_err_r <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= {CNT_W{1'b0}};
                    busy_r    <= 1'b0;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mdr_ctrl.md
Name: mdr_ctrl

Overview:
- Parametrised memory data register with its own memory handshake; successor to the single-cycle, always-latching MDR.
- Sits between the CPU datapath and the data memory port. Holds load data and store data, and drives a req/ack transaction to memory.
- Supports word and byte access, byte-lane steering and zero/sign extension.
- A bus timeout is built in so a missing memory acknowledge cannot hang the CPU.

Parameters:
- DATA_W, 16: data width in bits. Must be a multiple of 8 and ≥16.
- NB, DATA_W/8: number of byte lanes (derived; do not override).
- TIMEOUT, 8: cycles to wait for mem_ack before aborting. 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_rd_req  in  1  start a load; sampled only in IDLE.
- cpu_wr_req  in  1  start a store; sampled only in IDLE.
- cpu_size  in  1  0 = full word, 1 = byte.
- cpu_signed  in  1  byte loads: 1 = sign-extend, 0 = zero-extend.
- cpu_byte_sel  in  $clog2(NB)  byte lane for byte accesses.
- cpu_wdata  in  DATA_W  store data; byte stores use bits [7:0].
- cpu_rdata  out  DATA_W  load data register; holds its value until the next successful load.
- cpu_done  out  1  one-cycle pulse when a transaction completes or aborts.
- cpu_err  out  1  one-cycle pulse, coincident with cpu_done, on abort or error.
- busy  out  1  high in any state other than IDLE.
- mem_req  out  1  transaction request; held until ack or abort.
- mem_we  out  1  1 = write.
- mem_be  out  NB  byte enables.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data; valid in the mem_ack cycle.
- mem_ack  in  1  completion; one cycle.

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs cleared: cpu_rdata=0, cpu_done=0, cpu_err=0, busy=0, mem_req=0, mem_we=0, mem_be=0, mem_wdata=0, timeout counter=0.
- Reset mid-transaction: mem_req drops immediately, the transaction is lost, and no cpu_done is issued.
- FSM states: IDLE, RD, WR.
- IDLE:
  - If cpu_wr_req=1 → WR. Write has priority; a simultaneous cpu_rd_req is dropped, not queued.
  - Else if cpu_rd_req=1 → RD.
  - On entry to RD/WR, register mem_we, mem_be, mem_wdata, size, signed and byte_sel. CPU inputs may change afterwards.
- Request encoding:
  - Word access: mem_be = all ones; mem_wdata = cpu_wdata.
  - Byte access: mem_be = one-hot at cpu_byte_sel; mem_wdata = cpu_wdata[7:0] replicated across all lanes.
- RD/WR: mem_req=1 every cycle; the timeout counter increments each cycle.
  - mem_ack=1 → IDLE; pulse cpu_done the next cycle.
  - In RD, on ack, cpu_rdata is loaded:
    - Word: mem_rdata.
    - Byte: lane byte_sel, extended per the registered signed flag.
  - Counter reaches TIMEOUT without ack → IDLE; pulse cpu_done and cpu_err; cpu_rdata unchanged.
  - Ack in the same cycle the counter expires: ack wins, no error.
- Latency: request sampled at edge N → mem_req high from N+1. With ack in cycle K, cpu_done and the new cpu_rdata are visible after edge K+1, and busy is already low then. A new request is accepted in that same cycle, giving back-to-back throughput of one transaction per (ack latency + 1) cycles.
- Ignored inputs:
  - Requests while busy=1 are ignored.
  - mem_ack in IDLE is ignored.
  - mem_rdata is ignored outside the RD ack cycle.

Optional Feature:
- Macro: MDR_PARITY_EN.
- When defined:
  - Adds ports mem_wpar (out, NB) and mem_rpar (in, NB), one even-parity bit per byte lane.
  - Writes drive mem_wpar computed from mem_wdata.
  - On RD ack, parity is checked on enabled lanes only: the selected lane for byte loads, all lanes for word loads.
  - A mismatch pulses cpu_err with cpu_done. cpu_rdata is still loaded.
- When undefined: no parity ports or logic; cpu_err arises only from timeout.

Decomposition:
- Package mdr_pkg holds:
  - FSM state enum (IDLE/RD/WR).
  - Size encodings SZ_WORD=0 and SZ_BYTE=1.
  - Default DATA_W and TIMEOUT constants.
- Sub-module mdr_byte_ext: combinational lane select plus zero/sign extension, parametrised on DATA_W. It is reused by future halfword support.

Test Plan:
- Word read, DATA_W=16: rd_req, mem_ack two cycles after mem_req, mem_rdata=16'hBEEF → cpu_rdata=16'hBEEF, cpu_done pulses once, cpu_err=0, busy low after.
- Signed byte read: byte_sel=1, mem_rdata=16'h80AA → cpu_rdata=16'hFF80. With cpu_signed=0 → 16'h0080.
- Byte write: byte_sel=0, cpu_wdata=16'h1234 → mem_be=2'b01, mem_wdata=16'h3434, mem_we=1. Word write gives mem_be=2'b11 and mem_wdata=16'h1234.
- Timeout, TIMEOUT=8: no ack → mem_req high exactly 8 cycles, then cpu_done and cpu_err pulse, cpu_rdata unchanged. Repeat with ack on the 8th cycle → no error.
- Priority and ignore:
  - Simultaneous rd_req and wr_req → write only.
  - rd_req while busy → ignored.
  - Stray mem_ack in IDLE → no cpu_done.
- Reset mid-RD: rst_n low during mem_req → mem_req drops asynchronously, all outputs 0, no cpu_done after release.
- With MDR_PARITY_EN: flip mem_rpar[0] on a word read → cpu_err pulses with cpu_done, data still loaded.
